// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signal bundle of the cache-line adaptor.
// master is the adaptor's view; slave is the cache/memory view.
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic               read_i;
  logic               write_i;
  logic [ADDR_W-1:0]  address_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic               read_o;
  logic               write_o;
  logic [ADDR_W-1:0]  address_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;

  modport master (
    input  read_i, write_i, address_i, line_i,
    input  burst_i, resp_i,
    output line_o, resp_o,
    output read_o, write_o, address_o, burst_o
  );

  modport slave (
    output read_i, write_i, address_i, line_i,
    output burst_i, resp_i,
    input  line_o, resp_o,
    input  read_o, write_o, address_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one cache-line read/write into a fixed-length memory burst.
// Single outstanding transaction; one-cycle resp_o on completion.
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.master bus
);

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int OFFS   = $clog2(LINE_W / 8);
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] aligned;
  logic              last;
  logic              unused;

  // Offset bits within a line never reach memory.
  assign unused  = ^bus.address_i[OFFS-1:0];
  assign aligned = {bus.address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
  assign last    = (cnt_q == LAST);

  // State, beat counter, latched address and line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  // Next-state, beat placement and counter advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      IDLE: begin
        if (bus.read_i) begin
          addr_d  = aligned;
          state_d = RD;
        end else if (bus.write_i) begin
          addr_d  = aligned;
          line_d  = bus.line_i;
          state_d = WR;
        end
      end
      RD: begin
        if (bus.resp_i) begin
          line_d[cnt_q*BURST_W +: BURST_W] = bus.burst_i;
          if (last) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR: begin
        if (bus.resp_i) begin
          if (last) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs are pure decodes of the registered state.
  assign bus.read_o    = (state_q == RD);
  assign bus.write_o   = (state_q == WR);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = addr_q;
  assign bus.line_o    = line_q;
  assign bus.burst_o   = line_q[cnt_q*BURST_W +: BURST_W];

endmodule
